// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and oversampling constants,
// common to the receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

  // Tick counter must reach SB_TICK-1, so two stop bits need a fifth bit.
  function automatic int tick_cnt_w(input int sb_tick);
    return (sb_tick > OVERSAMPLE) ? 5 : 4;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset
// to RST_VAL so the synchronized output matches the line's idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver: start-bit validation at mid-bit, LSB-first
// data capture, stop-bit check, and a one-cycle completion strobe.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  localparam int SW = tick_cnt_w(SB_TICK);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID  = SW'(MID_TICK);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  logic rx_s;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_d;
  logic            frame_err_d;
  logic            done_d;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      n_q          <= '0;
      b_q          <= '0;
      dout         <= '0;
      frame_err    <= 1'b0;
      rx_done_tick <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      b_q          <= b_d;
      dout         <= dout_d;
      frame_err    <= frame_err_d;
      rx_done_tick <= done_d;
    end
  end

  // Every counter only advances on s_tick, so a stalled baud generator
  // freezes the frame in place; only the IDLE exit ignores the tick.
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    b_d         = b_q;
    dout_d      = dout;
    frame_err_d = frame_err;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            dout_d      = b_q;
            frame_err_d = ~rx_s;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

16x-oversampled UART receiver that consumes the one-cycle `s_tick` strobe from the baud generator and the asynchronous `rx` line. It detects a start bit, samples each data bit at mid-bit, checks the stop bit, and presents the received byte with a one-cycle completion strobe. It sits directly downstream of the baud generator and upstream of the byte consumer, such as the 7-segment decode/display path.

## Interface
- `DBIT`, 8: data bits per frame, sent LSB first; legal range 5..8.
- `SB_TICK`, 16: `s_tick` count for the stop bit (16 = 1 stop bit, 32 = 2 stop bits).
- `clk` input 1: system clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `s_tick` input 1: one-`clk`-wide strobe at 16x baud rate from the baud generator.
- `rx` input 1: serial line, idle high; asynchronous to `clk`.
- `dout` output DBIT: last received data word; held until the next frame completes.
- `rx_done_tick` output 1: high for exactly one `clk` when a frame completes.
- `frame_err` output 1: stop-bit level of the last frame was 0; updated together with `dout`.

## Operation
- `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
  - All FSM decisions use the synchronized value `rx_s`.
- Registers:
  - `s`: 4-bit tick counter, or 5-bit when `SB_TICK` is 32.
  - `n`: bit counter, width clog2(DBIT).
  - `b`: DBIT-bit shift register.
- States and transitions:
  - IDLE: when `rx_s`==0, go to START and set `s`=0. `s_tick` is not required for this transition.
  - START: on each `s_tick`, increment `s`. At the `s_tick` where `s`==7 (mid start bit):
    - if `rx_s`==0, go to DATA with `s`=0 and `n`=0;
    - otherwise treat it as a glitch and return to IDLE with no output change.
  - DATA: at the `s_tick` where `s`==15:
    - shift in with `b` <= {`rx_s`, `b`[DBIT-1:1]} and set `s`=0;
    - if `n`==DBIT-1, go to STOP; otherwise increment `n`.
  - STOP: at the `s_tick` where `s`==SB_TICK-1, do all of the following:
    - `dout` <= `b`;
    - `frame_err` <= ~`rx_s`;
    - `rx_done_tick` <= 1;
    - go to IDLE.
- A frame with a 0 stop bit still completes: it updates `dout`, pulses `rx_done_tick` and sets `frame_err`=1.
  - If the line then stays low, IDLE sees `rx_s`==0 and starts a new frame. This is the required behaviour for break conditions.
- Without `s_tick`, all counters hold. A stalled `s_tick` freezes the FSM in its current state.
- Reset values:
  - state IDLE, `s`=0, `n`=0, `b`=0;
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0;
  - synchronizer flops = 1.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs at their reset values, and there is no `rx_done_tick`. After release, the FSM resynchronizes on the next falling edge.

## Timing
- Input latency: a change on `rx` reaches `rx_s` after 2 `clk` edges.
- Sample points, relative to the start-bit edge seen on `rx_s`:
  - start bit checked at the 8th `s_tick`;
  - data bit k sampled at tick 8+16(k+1);
  - stop bit sampled at tick 8+16·DBIT+SB_TICK.
- `rx_done_tick` is registered: it rises on the `clk` edge that processes the final stop-bit `s_tick` and falls on the next edge.
  - `dout` and `frame_err` are valid on that same edge and stable until the next completion.
- There is no back-pressure or ready input. The consumer must capture `dout` within one frame time.
- Back-to-back frames: the stop bit ends 8 ticks into its nominal period (half-bit early). This tolerates up to ±3% baud mismatch.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - OVERSAMPLE=16 and MID_TICK=7, reused by a future `uart_tx`.
- One sub-module, `sync_2ff`: a 2-flop synchronizer with parameterized reset value, here 1.
- FSM, counters and shift register live in `uart_rx`.

## Test plan
All scenarios drive `s_tick` from the baud generator with N=4, giving a 4-clk tick and a 64-clk bit period.
- 8N1 byte 0xA5 on `rx` -> exactly one `rx_done_tick`; `dout`=0xA5; `frame_err`=0; pulse ~2 clk after the last stop `s_tick`.
- `rx` low for 3 ticks, then high -> FSM returns to IDLE; no `rx_done_tick`; `dout` keeps its previous value.
- Frame 0x3C with stop bit 0 -> `rx_done_tick`; `dout`=0x3C; `frame_err`=1. Next valid frame 0x81 -> `frame_err`=0.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap, `rx` baud skewed +2% -> three pulses; `dout` sequence 0x00, 0xFF, 0x55.
- `rst_n` pulsed low during data bit 4 of 0xC3 -> no pulse; `dout`=0. The following clean frame 0x7E is received correctly.
- `s_tick` gated off for 100 clk mid-DATA, then resumed -> the FSM freezes, then completes the frame with the correct byte.
